// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: combinational decode of one instruction word
// into a 2-entry result FIFO, plus a saturating illegal-instruction counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
  localparam bit         RV64     = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } ent_t;

  ent_t       dec;
  ent_t       mem [2];
  ent_t       head;
  logic       wp, rp;
  logic [1:0] cnt;
  logic       push, pop;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       sl_ok, sr_ok, slw_ok, srw_ok;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  // shift upper-field checks; the *w forms always carry a 5-bit shamt
  assign slw_ok = (instr[31:25] == 7'b0000000);
  assign srw_ok = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
  assign sl_ok  = RV64 ? (instr[31:26] == 6'b000000) : slw_ok;
  assign sr_ok  = RV64 ? ((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000)) : srw_ok;

  always_comb begin
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(instr[31:20]));
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if ((f3 == 3'b001) ? sl_ok : sr_ok) begin
            dec.fmt = FMT_SH;
            dec.imm = RV64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
          end else begin
            dec.illegal = 1'b1;
          end
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(instr[31:20]));
        end
      end
      7'b0011011: begin
        if (!RV64) begin
          dec.illegal = 1'b1;
        end else if (f3 == 3'b000) begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(instr[31:20]));
        end else if ((f3 == 3'b001 && slw_ok) || (f3 == 3'b101 && srw_ok)) begin
          dec.fmt = FMT_SH;
          dec.imm = XLEN'(instr[24:20]);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      7'b0110011: ;
      7'b0111011: dec.illegal = !RV64;
      default:    dec.illegal = 1'b1;
    endcase
  end

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      ill_cnt <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= dec;
        wp      <= ~wp;
        if (dec.illegal && ill_cnt != {CNT_W{1'b1}})
          ill_cnt <= ill_cnt + CNT_W'(1);
      end
      if (pop)
        rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // result fields are forced to zero while reset is held
  assign head    = mem[rp];
  assign imm     = rst ? '0 : head.imm;
  assign fmt     = rst ? FMT_NONE : head.fmt;
  assign illegal = rst ? 1'b0 : head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance share stimulus.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [3:0]  cnt32, cnt64;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(4)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .out_valid(vld32), .out_ready(out_ready), .imm(imm32),
    .fmt(fmt32), .illegal(ill32), .ill_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .CNT_W(4)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .out_valid(vld64), .out_ready(out_ready), .imm(imm64),
    .fmt(fmt64), .illegal(ill64), .ill_cnt(cnt64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0; instr = 32'hFFF00093;
    tick(); tick();
    checks++;
    if ({vld32, imm32, fmt32, ill32, cnt32} !== {1'b0, 32'h0, 3'd0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_hold: vld=%b imm=%h fmt=%0d ill=%b cnt=%0d, want 0s", vld32, imm32, fmt32, ill32, cnt32);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if ({vld32, rdy32, cnt32, vld64, rdy64} !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_after: vld=%b rdy=%b cnt=%0d vld64=%b rdy64=%b", vld32, rdy32, cnt32, vld64, rdy64);
    end
  endtask

  task automatic test_decode32();
    logic [31:0] vin [9] = '{32'hFFF00093, 32'hFE20AC23, 32'hFE000EE3, 32'h002081B3,
                             32'h800000B7, 32'h40001093, 32'h00000001, 32'h0000001B, 32'h0000003B};
    logic [31:0] vimm[9] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0,
                             32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [2:0]  vfmt[9] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    logic        vill[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; instr = vin[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if ({vld32, imm32, fmt32, ill32} !== {1'b1, vimm[i], vfmt[i], vill[i]}) begin
        errors++;
        $display("FAIL dec32[%0d] %h: vld=%b imm=%h fmt=%0d ill=%b, want 1 %h %0d %b",
                 i, vin[i], vld32, imm32, fmt32, ill32, vimm[i], vfmt[i], vill[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h41F0D093;
    tick();
    checks++;
    if ({vld32, imm32, fmt32, ill32} !== {1'b1, 32'h0000001F, 3'd6, 1'b0}) begin
      errors++;
      $display("FAIL b2b_srai: vld=%b imm=%h fmt=%0d ill=%b, want 1 0000001f 6 0", vld32, imm32, fmt32, ill32);
    end
    instr = 32'hFFDFF06F;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({vld32, rdy32, imm32, fmt32, ill32} !== {1'b1, 1'b1, 32'hFFFFFFFC, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL b2b_jal: vld=%b rdy=%b imm=%h fmt=%0d ill=%b, want 1 1 fffffffc 5 0", vld32, rdy32, imm32, fmt32, ill32);
    end
    tick();
    checks++;
    if (vld32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: vld=%b, want 0", vld32);
    end
  endtask

  task automatic test_rv64();
    logic [31:0] vin [7] = '{32'h800000B7, 32'h0000001B, 32'h02109093, 32'h0000003B,
                             32'hFFF00093, 32'hFFDFF06F, 32'h8000D093};
    logic [63:0] vimm[7] = '{64'hFFFFFFFF80000000, 64'h0, 64'h21, 64'h0,
                             64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0};
    logic [2:0]  vfmt[7] = '{3'd4, 3'd1, 3'd6, 3'd0, 3'd1, 3'd5, 3'd0};
    logic        vill[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; instr = vin[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if ({vld64, imm64, fmt64, ill64} !== {1'b1, vimm[i], vfmt[i], vill[i]}) begin
        errors++;
        $display("FAIL dec64[%0d] %h: vld=%b imm=%h fmt=%0d ill=%b, want 1 %h %0d %b",
                 i, vin[i], vld64, imm64, fmt64, ill64, vimm[i], vfmt[i], vill[i]);
      end
      tick();
    end
  endtask

  task automatic test_fifo_order();
    logic [31:0] exp_imm [3] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC};
    logic [2:0]  exp_fmt [3] = '{3'd1, 3'd2, 3'd3};
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF00093;
    tick();
    instr = 32'hFE20AC23;
    tick();
    instr = 32'hFE000EE3;
    tick();
    checks++;
    if ({rdy32, vld32, imm32} !== {1'b0, 1'b1, exp_imm[0]}) begin
      errors++;
      $display("FAIL fifo_full: rdy=%b vld=%b imm=%h, want 0 1 %h", rdy32, vld32, imm32, exp_imm[0]);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if ({vld32, imm32, fmt32} !== {1'b1, exp_imm[i], exp_fmt[i]}) begin
        errors++;
        $display("FAIL fifo_order[%0d]: vld=%b imm=%h fmt=%0d, want 1 %h %0d", i, vld32, imm32, fmt32, exp_imm[i], exp_fmt[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (vld32 !== 1'b0) begin
      errors++;
      $display("FAIL fifo_dup: vld=%b, want 0", vld32);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({vld32, ill32, fmt32, imm32} !== {1'b1, 1'b1, 3'd0, 32'h0}) begin
        errors++;
        $display("FAIL zero_ill[%0d]: vld=%b ill=%b fmt=%0d imm=%h, want 1 1 0 0", i, vld32, ill32, fmt32, imm32);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (cnt32 !== 4'd3) begin
      errors++;
      $display("FAIL ill_cnt3: cnt=%0d, want 3", cnt32);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF00093;
    tick(); tick();
    checks++;
    if (rdy32 !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: rdy=%b, want 0", rdy32);
    end
    flush = 1'b1; instr = 32'h00000000;
    tick();
    flush = 1'b0;
    checks++;
    if ({vld32, rdy32, cnt32} !== {1'b0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL flush: vld=%b rdy=%b cnt=%0d, want 0 1 3", vld32, rdy32, cnt32);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({vld32, cnt32} !== {1'b0, 4'd3}) begin
      errors++;
      $display("FAIL flush_drop: vld=%b cnt=%0d, want 0 3", vld32, cnt32);
    end
  endtask

  task automatic test_ill_cnt();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF00093;
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({imm32, fmt32, ill32} !== {32'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_gate: imm=%h fmt=%0d ill=%b, want 0 0 0", imm32, fmt32, ill32);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({vld32, rdy32, cnt32} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL rst_mid: vld=%b rdy=%b cnt=%0d, want 0 1 0", vld32, rdy32, cnt32);
    end
    in_valid = 1'b1; instr = 32'h00000000;
    repeat (15) tick();
    checks++;
    if (cnt32 !== 4'hF) begin
      errors++;
      $display("FAIL ill_cnt15: cnt=%0d, want 15", cnt32);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({cnt32, cnt64} !== {4'hF, 4'hF}) begin
      errors++;
      $display("FAIL ill_sat: cnt32=%0d cnt64=%0d, want 15 15", cnt32, cnt64);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cnt32, cnt64, vld32} !== {4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL ill_rst: cnt32=%0d cnt64=%0d vld=%b, want 0 0 0", cnt32, cnt64, vld32);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    test_reset();
    test_decode32();
    test_back_to_back();
    test_rv64();
    test_fifo_order();
    test_flush();
    test_ill_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
